// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-hot column strobe, debounced press/release, single-entry valid/ready key register.
// Optional KEYPAD_ROW_SYNC_EN adds a two-flop synchroniser on row_in (requires SETTLE_CYCLES >= 3).
module keypad_scan_ctrl #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE_CYCLES   = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CODE_W         = $clog2(ROWS*COLS)
) (
  input  logic              slow_clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_drive,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic              key_release,
  output logic              overrun
);

  // state    | meaning
  // SCAN     | strobing columns, evaluate rows on last settle cycle
  // DEBOUNCE | single key seen, counting stable samples
  // PRESSED  | press committed, watching the captured row bit
  // RELEASE  | captured row bit low, counting stable-low samples

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  // The PRESSED cycle that first sees the bit low counts as one release sample.
  localparam logic [DW-1:0] REL_LAST    = DW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [ROWS-1:0]   rs;
  logic [ROWS-1:0]   cap_row;
  logic [RW-1:0]     row_idx, rs_idx;
  logic [CW-1:0]     col_idx;
  logic [SW-1:0]     settle_cnt;
  logic [DW-1:0]     deb_cnt;
  logic [CODE_W-1:0] new_code;
  logic              rs_onehot;
  logic              settle_inc, deb_inc, capture, commit, rel_done, rotate;

`ifdef KEYPAD_ROW_SYNC_EN
  logic [ROWS-1:0] sync_q1, sync_q2;

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= row_in;
      sync_q2 <= sync_q1;
    end
  end

  assign rs = sync_q2;

  if (SETTLE_CYCLES < 3) begin : g_settle_check
    $error("keypad_scan_ctrl: SETTLE_CYCLES must be >= 3 with the row synchroniser");
  end
`else
  logic [ROWS-1:0] rs_q;

  always_ff @(posedge slow_clk) begin
    if (rst) rs_q <= '0;
    else     rs_q <= row_in;
  end

  assign rs = rs_q;
`endif

  always_comb begin
    rs_onehot = (rs != '0) && ((rs & (rs - ROWS'(1))) == '0);
    rs_idx    = '0;
    for (int i = 0; i < ROWS; i++)
      if (rs[i]) rs_idx = RW'(i);
  end

  assign new_code = CODE_W'(row_idx) * CODE_W'(COLS) + CODE_W'(col_idx);

  always_ff @(posedge slow_clk) begin
    if (rst) state <= SCAN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:     if (settle_cnt == SETTLE_LAST && rs_onehot) state_nxt = DEBOUNCE;
      DEBOUNCE: if (rs != cap_row)                          state_nxt = SCAN;
                else if (deb_cnt == DEB_LAST)               state_nxt = PRESSED;
      PRESSED:  if (!rs[row_idx])
                  state_nxt = (DEBOUNCE_CYCLES == 1) ? SCAN : RELEASE;
      RELEASE:  if (rs[row_idx])                            state_nxt = PRESSED;
                else if (deb_cnt == REL_LAST)               state_nxt = SCAN;
      default:                                              state_nxt = SCAN;
    endcase
  end

  always_comb begin
    settle_inc = 1'b0;
    deb_inc    = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    rel_done   = 1'b0;
    rotate     = 1'b0;
    case (state)
      SCAN: begin
        if (settle_cnt != SETTLE_LAST) settle_inc = 1'b1;
        else if (rs_onehot)            capture    = 1'b1;
        else                           rotate     = 1'b1;
      end
      DEBOUNCE: begin
        if (rs == cap_row) begin
          if (deb_cnt == DEB_LAST) commit  = 1'b1;
          else                     deb_inc = 1'b1;
        end
      end
      PRESSED: begin
        if (!rs[row_idx] && DEBOUNCE_CYCLES == 1) begin
          rel_done = 1'b1;
          rotate   = 1'b1;
        end
      end
      RELEASE: begin
        if (!rs[row_idx]) begin
          if (deb_cnt == REL_LAST) begin
            rel_done = 1'b1;
            rotate   = 1'b1;
          end else begin
            deb_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      settle_cnt  <= '0;
      deb_cnt     <= '0;
      col_drive   <= COLS'(1);
      col_idx     <= '0;
      cap_row     <= '0;
      row_idx     <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      settle_cnt <= settle_inc ? settle_cnt + SW'(1) : '0;
      deb_cnt    <= deb_inc ? deb_cnt + DW'(1) : '0;
      if (rotate) begin
        col_drive <= {col_drive[COLS-2:0], col_drive[COLS-1]};
        col_idx   <= (col_idx == COL_LAST) ? '0 : col_idx + CW'(1);
      end
      if (capture) begin
        cap_row <= rs;
        row_idx <= rs_idx;
      end
      key_release <= rel_done;
      key_held    <= (state_nxt == PRESSED) || (state_nxt == RELEASE);
      overrun     <= commit && key_valid && !key_ready;
      // A consumed slot can be refilled by a commit on the same edge.
      if (commit && (!key_valid || key_ready)) begin
        key_code  <= new_code;
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule
